// File: rtl/rotate_arb_32.sv
// Two-requester arbiter in front of a shared 32-bit rotator with a one-entry result register.
// Round-robin or fixed-priority grant; op_count tallies accepted operations.
module rotate_arb_32 #(
   parameter int unsigned ROUND_ROBIN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_data,
   input  logic [4:0]  req0_amt,
   input  logic        req0_dir,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_data,
   input  logic [4:0]  req1_amt,
   input  logic        req1_dir,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_id,
   output logic [15:0] op_count
);

   logic        r_res_valid;
   logic [31:0] r_res_data;
   logic        r_res_id;
   logic [15:0] r_op_count;
   logic        r_last_grant;

   logic        w_slot_free;
   logic        w_any_valid;
   logic        w_grant;
   logic        w_accept;
   logic [31:0] w_op_data;
   logic [4:0]  w_op_amt;
   logic        w_op_dir;
   logic [4:0]  w_left_amt;
   logic [31:0] w_rot;
   logic        w_res_valid_nxt;
   logic [31:0] w_res_data_nxt;
   logic        w_res_id_nxt;
   logic [15:0] w_op_count_nxt;
   logic        w_last_grant_nxt;

   // Bit i of the result is d[(i - k) mod 32]; the upper half of {d, d} << k gives exactly that.
   function automatic logic [31:0] rotl(input logic [31:0] d, input logic [4:0] k);
      logic [63:0] w_wide;
      w_wide = {d, d} << k;
      return w_wide[63:32];
   endfunction

   assign w_slot_free = ~r_res_valid | res_ready;
   assign w_any_valid = req0_valid | req1_valid;

   always_comb begin
      w_grant = 1'b0;
      if (req0_valid && req1_valid) begin
         w_grant = (ROUND_ROBIN != 0) ? ~r_last_grant : 1'b0;
      end else begin
         w_grant = req1_valid;
      end
   end

   assign w_accept   = rst_n & w_slot_free & w_any_valid;
   assign req0_ready = rst_n & w_slot_free & req0_valid & ~w_grant;
   assign req1_ready = rst_n & w_slot_free & req1_valid & w_grant;

   // Operand mux driven by the grant so a single rotator serves both requesters.
   assign w_op_data  = w_grant ? req1_data : req0_data;
   assign w_op_amt   = w_grant ? req1_amt  : req0_amt;
   assign w_op_dir   = w_grant ? req1_dir  : req0_dir;
   assign w_left_amt = w_op_dir ? (5'd0 - w_op_amt) : w_op_amt;
   assign w_rot      = rotl(w_op_data, w_left_amt);

   always_comb begin
      w_res_valid_nxt  = r_res_valid;
      w_res_data_nxt   = r_res_data;
      w_res_id_nxt     = r_res_id;
      w_op_count_nxt   = r_op_count;
      w_last_grant_nxt = r_last_grant;
      if (w_accept) begin
         w_res_valid_nxt  = 1'b1;
         w_res_data_nxt   = w_rot;
         w_res_id_nxt     = w_grant;
         w_op_count_nxt   = r_op_count + 16'd1;
         w_last_grant_nxt = w_grant;
      end else if (r_res_valid && res_ready) begin
         w_res_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_valid  <= 1'b0;
         r_res_data   <= 32'h0000_0000;
         r_res_id     <= 1'b0;
         r_op_count   <= 16'h0000;
         r_last_grant <= 1'b1;
      end else begin
         r_res_valid  <= w_res_valid_nxt;
         r_res_data   <= w_res_data_nxt;
         r_res_id     <= w_res_id_nxt;
         r_op_count   <= w_op_count_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;
   assign res_id    = r_res_id;
   assign op_count  = r_op_count;

   a_ready_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
      !(req0_ready && req1_ready));
   a_no_ready_on_stall : assert property (@(posedge clk) disable iff (!rst_n)
      (r_res_valid && !res_ready) |-> !(req0_ready || req1_ready));

endmodule

// File: doc/rotate_arb_32.md
ROTATE_ARB_32 -- requirements
Module: rotate_arb_32

Interface
REQ-001 Parameter ROUND_ROBIN, default 1, meaning: 1 = round-robin grant between requesters; 0 = fixed priority, requester 0 always wins.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high together with req0_valid.
REQ-006 req0_data  input  32  requester 0 operand.
REQ-007 req0_amt  input  5  requester 0 rotate amount, 0-31.
REQ-008 req0_dir  input  1  requester 0 direction: 0 = rotate left, 1 = rotate right.
REQ-009 req1_valid, req1_ready, req1_data, req1_amt, req1_dir  same directions, widths and meanings as REQ-004..REQ-008, for requester 1.
REQ-010 res_valid  output  1  result register holds a valid result.
REQ-011 res_ready  input  1  consumer accepts the result when high together with res_valid.
REQ-012 res_data  output  32  rotated result.
REQ-013 res_id  output  1  index of the requester that issued the result.
REQ-014 op_count  output  16  number of operations accepted since reset, wraps 0xFFFF -> 0x0000.

Function
REQ-015 The block SHALL contain one 32-bit rotate datapath shared by both requesters, followed by a single one-entry output register.
REQ-016 The slot is free when res_valid = 0, or when res_valid = 1 and res_ready = 1 in the same cycle (drain-and-refill allowed, full throughput of one op/cycle).
REQ-017 Grant: if only one req*_valid is high, that requester is granted; if both are high, grant goes to the requester not held in last_grant (ROUND_ROBIN = 1), or to requester 0 (ROUND_ROBIN = 0).
REQ-018 reqN_ready SHALL be high only for the granted requester and only when the slot is free; the non-granted requester's ready SHALL be 0.
REQ-019 reqN_ready MAY depend combinationally on both valids and res_ready; requesters SHALL NOT make valid depend on ready.
REQ-020 Accept (valid & ready of the granted requester): on the next edge res_data <= rotate(data, amt, dir), res_id <= N, res_valid <= 1, last_grant <= N, op_count <= op_count + 1; latency is 1 cycle from acceptance to res_valid.
REQ-021 Rotate left by k: bit i of result = data[(i - k) mod 32]; rotate right by k SHALL equal rotate left by (32 - k) mod 32; k = 0 SHALL return data unchanged in both directions.
REQ-022 When res_valid = 1 and res_ready = 0, res_data, res_id and res_valid SHALL hold stable, and both reqN_ready SHALL be 0.
REQ-023 When the result drains (res_valid & res_ready) and no accept occurs that cycle, res_valid <= 0 on the next edge; res_data and res_id retain their last values.
REQ-024 last_grant SHALL change only on an accept; idle cycles and stalls do not alter arbitration order.
REQ-025 Requester operands are sampled only in the accept cycle; changes to data/amt/dir while not accepted have no effect.
REQ-026 res_ready high while res_valid = 0 SHALL have no effect.

Reset
REQ-027 While rst_n = 0: res_valid = 0, res_data = 0x00000000, res_id = 0, op_count = 0, last_grant = 1 (requester 0 wins first contention), req0_ready = req1_ready = 0.
REQ-028 Reset asserted mid-operation SHALL discard any held result immediately and asynchronously; no partial state survives.
REQ-029 After rst_n deasserts, the first accept is possible on the first rising edge with the slot free.

Verification
REQ-030 Req0 only, data 0x80000001, amt 1, dir 0, res_ready = 1 -> next cycle res_valid = 1, res_data 0x00000003, res_id 0, op_count 1.
REQ-031 Req1 only, data 0x12345678, amt 4, dir 1 -> res_data 0x81234567, res_id 1; amt 0 with either dir -> res_data = 0x12345678.
REQ-032 Both valid continuously for 4 cycles, res_ready = 1, ROUND_ROBIN = 1 -> res_id sequence 0,1,0,1, one result per cycle, op_count 4; with ROUND_ROBIN = 0 -> 0,0,0,0.
REQ-033 Result held with res_ready = 0 for 3 cycles while both requesters valid -> res_data/res_id stable, both ready 0; res_ready = 1 in cycle 4 -> next op accepted that same cycle, res_valid stays 1.
REQ-034 rst_n pulsed low while res_valid = 1 and op_count = 5 -> res_valid, res_data, op_count read 0 before the next clock edge; first post-reset contention grants requester 0.
REQ-035 op_count preloaded by 65535 accepts, one more accept -> op_count = 0x0000.
